regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port register file: the next-generation register file for the datapath. It replaces the fixed 32×32, 2-read/1-write file with configurable width, depth and read-port count. It adds:
- a second write port with defined priority,
- write-to-read forwarding,
- an optional registered-read mode,
- a pending-write scoreboard for pipeline hazard detection.

It sits between decode (read addresses, reservations) and writeback (two retire lanes).

## Interface
Parameters:
- DATA_W, 32, data width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W
- N_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to matching reads
- RD_REG, 0, 0 = combinational read; 1 = read data registered (1-cycle latency)

Ports:
- clk  in  1  clock, all state updates on rising edge
- clr  in  1  reset; one clock, reset is synchronous and active-high
- we  in  2  write enables, bit k for write port k
- wr_addr  in  2×ADDR_W  write addresses, port k
- wr_data  in  2×DATA_W  write data, port k
- rd_addr  in  N_RD×ADDR_W  read addresses
- rd_data  out  N_RD×DATA_W  read data
- rsv_en  in  1  reserve register (mark pending write)
- rsv_addr  in  ADDR_W  register to reserve
- busy  out  DEPTH  pending-write bit per register
- wr_conflict  out  1  registered flag: both write ports hit the same address last cycle

## Operation
- Write: at the rising edge, if we[k], mem[wr_addr[k]] <= wr_data[k].
- Both ports enabled with equal address: port 1 wins. wr_conflict = 1 the next cycle, else 0.
- ZERO_REG=1: writes to address 0 are dropped and produce no conflict flag. Address 0 reads 0 and busy[0] is constant 0.
- Read, BYPASS=1: if a read address matches an enabled write address this cycle, that read returns the write data (port 1 over port 0). Otherwise it returns mem[rd_addr]. The zero-register rule overrides forwarding.
- Read, BYPASS=0: returns the stored value only; new data is visible the cycle after the write.
- RD_REG=1: rd_data is the above value captured at the edge, so data appears 1 cycle after the address.
- Scoreboard, per register:
  - set by rsv_en at rsv_addr;
  - cleared by any enabled write to that address;
  - same-cycle reserve and write to one address: busy ends set, because the reserve belongs to a newer producer.
- clr=1 at an edge:
  - all mem entries <= 0, busy <= 0, wr_conflict <= 0, registered rd_data <= 0;
  - clr overrides writes and reservations in the same cycle.

## Timing
- Reset values: mem all 0, busy all 0, wr_conflict 0, rd_data 0.
  - RD_REG=1: rd_data is held 0 by the output register.
  - RD_REG=0: rd_data is 0 because mem is 0.
- Write-to-read latency: 0 cycles with BYPASS=1; 1 cycle with BYPASS=0. RD_REG adds 1 cycle in either case.
- busy update: 1 cycle after rsv_en or the write.
- wr_conflict: asserted exactly 1 cycle after the colliding cycle, held for 1 cycle per collision.
- No handshakes: all inputs are sampled every cycle. Out-of-range N_RD is rejected by an elaboration-time assertion.

## Structure
- Package regfile_pkg holds:
  - defaults DATA_W_DEF=32, ADDR_W_DEF=5, MAX_RD=4, N_WR=2;
  - typedef wr_req_t {we, addr, data} for writeback lanes.
- Sub-module regfile_scoreboard (DEPTH bits, reserve/clear/clr logic) is separated so that decode can later instantiate it standalone.
- Storage, write priority, forwarding and read registers stay in regfile_mp.

## Test plan
- Reset and basic write/read: clr for 2 cycles. Then we=01, wr_addr[0]=5, wr_data[0]=0xDEADBEEF. Next cycle rd_addr[0]=5 -> rd_data[0]=0xDEADBEEF. All other reads = 0.
- Port priority: we=11, both addresses 7, data 0x11 (port 0) and 0x22 (port 1). Next cycle read 7 -> 0x22, wr_conflict=1 for exactly one cycle.
- Forwarding: BYPASS=1, write 0xCAFE to reg 3 while rd_addr[1]=3 in the same cycle -> rd_data[1]=0xCAFE that cycle. With BYPASS=0, old value that cycle and 0xCAFE the next.
- Zero register: write 0xFFFF to reg 0 on both ports -> reads of reg 0 = 0, wr_conflict=0. rsv_en with rsv_addr=0 -> busy[0]=0.
- Scoreboard: reserve reg 9 -> busy[9]=1 next cycle. Write reg 9 while reserving reg 9 in the same cycle -> busy[9] stays 1. A later write without reserve -> busy[9]=0.
- Reset mid-operation with RD_REG=1: fill regs 1..4, reserve reg 2. Then assert clr in the same cycle as a write of 0x5 to reg 4 -> next cycle all reads 0, busy all 0, and reg 4 stays 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
//   DATA_W_DEF / ADDR_W_DEF : default data and address widths
//   MAX_RD                  : largest supported read-port count
//   N_WR                    : number of writeback lanes (write ports)
//   wr_req_t                : one writeback lane at default widths
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned MAX_RD     = 4;
  localparam int unsigned N_WR       = 2;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
//   clk       : clock, rising edge
//   clr       : synchronous active-high clear of all busy bits
//   rsv_en_i  : mark rsv_addr_i as having a pending producer
//   rsv_addr_i: register to reserve
//   wen_i     : per-lane write enables that retire a pending write
//   waddr_i   : per-lane write addresses, lane k at [k*ADDR_W +: ADDR_W]
//   busy_o    : busy bit per register
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned Depth   = 2 ** ADDR_W
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   rsv_en_i,
  input  logic [ADDR_W-1:0]      rsv_addr_i,
  input  logic [N_WR-1:0]        wen_i,
  input  logic [N_WR*ADDR_W-1:0] waddr_i,
  output logic [Depth-1:0]       busy_o
);

  logic [Depth-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < N_WR; k++) begin
      if (wen_i[k]) busy_d[waddr_i[k*ADDR_W +: ADDR_W]] = 1'b0;
    end
    // Reserve after clear: a same-cycle reserve belongs to a newer producer.
    if (rsv_en_i) busy_d[rsv_addr_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  always_comb begin
    busy_o = busy_q;
    if (ZERO_REG != 0) busy_o[0] = 1'b0;
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with two write ports (port 1 wins),
// optional write-to-read forwarding, optional registered reads and a
// pending-write scoreboard.
//   clk         : clock, rising edge
//   clr         : synchronous active-high reset
//   we          : write enables, bit k for port k
//   wr_addr     : write addresses, port k at [k*ADDR_W +: ADDR_W]
//   wr_data     : write data, port k at [k*DATA_W +: DATA_W]
//   rd_addr     : read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data     : read data, port i at [i*DATA_W +: DATA_W]
//   rsv_en      : reserve rsv_addr (mark pending write)
//   rsv_addr    : register to reserve
//   busy        : pending-write bit per register
//   wr_conflict : both write ports hit the same address last cycle
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned N_RD     = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned RD_REG   = 0,
  localparam int unsigned Depth   = 2 ** ADDR_W
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic [N_WR-1:0]        we,
  input  logic [N_WR*ADDR_W-1:0] wr_addr,
  input  logic [N_WR*DATA_W-1:0] wr_data,
  input  logic [N_RD*ADDR_W-1:0] rd_addr,
  output logic [N_RD*DATA_W-1:0] rd_data,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic [Depth-1:0]       busy,
  output logic                   wr_conflict
);

  if (N_RD < 1 || N_RD > MAX_RD) begin : g_bad_n_rd
    $fatal(1, "regfile_mp: N_RD out of range 1..4");
  end

  logic [DATA_W-1:0] mem_q [Depth];
  logic [ADDR_W-1:0] waddr [N_WR];
  logic [DATA_W-1:0] wdata [N_WR];
  logic [N_WR-1:0]   wen;
  logic              wr_conflict_q;
  logic [N_RD*DATA_W-1:0] rd_comb;

  for (genvar k = 0; k < N_WR; k++) begin : g_wr
    assign waddr[k] = wr_addr[k*ADDR_W +: ADDR_W];
    assign wdata[k] = wr_data[k*DATA_W +: DATA_W];
  end

  // Effective enables: writes to the hardwired zero register are dropped.
  always_comb begin
    wen = we;
    for (int k = 0; k < N_WR; k++) begin
      if (ZERO_REG != 0 && waddr[k] == '0) wen[k] = 1'b0;
    end
  end

  // Higher port index assigned last, so port 1 wins an address collision.
  always_ff @(posedge clk) begin
    if (clr) begin
      mem_q <= '{default: '0};
    end else begin
      for (int k = 0; k < N_WR; k++) begin
        if (wen[k]) mem_q[waddr[k]] <= wdata[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) wr_conflict_q <= 1'b0;
    else     wr_conflict_q <= wen[0] && wen[1] && (waddr[0] == waddr[1]);
  end
  assign wr_conflict = wr_conflict_q;

  for (genvar g = 0; g < N_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;
    assign ra = rd_addr[g*ADDR_W +: ADDR_W];
    always_comb begin
      val = mem_q[ra];
      if (BYPASS != 0) begin
        for (int k = 0; k < N_WR; k++) begin
          if (wen[k] && waddr[k] == ra) val = wdata[k];
        end
      end
      if (ZERO_REG != 0 && ra == '0) val = '0;
    end
    assign rd_comb[g*DATA_W +: DATA_W] = val;
  end

  if (RD_REG != 0) begin : g_rd_reg
    logic [N_RD*DATA_W-1:0] rd_q;
    always_ff @(posedge clk) begin
      if (clr) rd_q <= '0;
      else     rd_q <= rd_comb;
    end
    assign rd_data = rd_q;
  end else begin : g_rd_comb
    assign rd_data = rd_comb;
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .clr       (clr),
    .rsv_en_i  (rsv_en),
    .rsv_addr_i(rsv_addr),
    .wen_i     (wen),
    .waddr_i   (wr_addr),
    .busy_o    (busy)
  );

endmodule
